// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: queues pixel writes into a 320x240 framebuffer and performs full-screen clears.
// Optional colour-key skipping is enabled with macro PIXEL_PLOT_SINK_TRANSPARENT_EN.
module pixel_plot_sink #(
    parameter int         DEPTH       = 4,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] TRANSPARENT = 3'b101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    output logic        ready,
    input  logic        clear,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        busy,
    output logic        dropped
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] LAST = 17'd76799;

    typedef enum logic [1:0] {RUN, FLUSH, CLEAR} state_t;

    state_t state, state_n;
    logic [19:0] fifo [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [16:0] clr_addr, addr;
    logic [19:0] head;
    logic out_clr, in_range, keep, empty, full, take, pop, bypass, push;

    assign addr = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
    assign in_range = (x < 9'd320) && (y < 8'd240);
`ifdef PIXEL_PLOT_SINK_TRANSPARENT_EN
    assign keep = in_range && (colour != TRANSPARENT);
`else
    logic unused_key;
    assign unused_key = ^TRANSPARENT;
    assign keep = in_range;
`endif
    assign empty = (count == '0);
    assign full = (count == (AW+1)'(DEPTH));
    assign head = fifo[rp];
    assign busy = !empty || (state != RUN) || out_clr;

    always_comb begin
        state_n = state;
        ready = !full && (state == RUN);
        case (state)
            RUN:     state_n = clear ? FLUSH : RUN;
            FLUSH:   state_n = empty ? CLEAR : FLUSH;
            CLEAR:   state_n = (clr_addr == LAST) ? RUN : CLEAR;
            default: state_n = RUN;
        endcase
        take = plot && ready;
        pop = (state != CLEAR) && !empty;
        // An accepted pixel skips the FIFO when nothing is queued ahead of it.
        bypass = take && keep && empty;
        push = take && keep && !empty;
    end

    always_ff @(posedge clock)
        if (push)
            fifo[wp] <= {addr, colour};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            wp <= '0;
            rp <= '0;
            count <= '0;
            clr_addr <= '0;
            out_clr <= 1'b0;
            dropped <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state <= state_n;
            wp <= push ? wp + 1'b1 : wp;
            rp <= pop ? rp + 1'b1 : rp;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            clr_addr <= (state == CLEAR) ? clr_addr + 17'd1 : '0;
            out_clr <= (state == CLEAR);
            dropped <= take && !in_range;
            mem_we <= pop || bypass || (state == CLEAR);
            if (pop) begin
                mem_addr <= head[19:3];
                mem_data <= head[2:0];
            end else if (bypass) begin
                mem_addr <= addr;
                mem_data <= colour;
            end else if (state == CLEAR) begin
                mem_addr <= clr_addr;
                mem_data <= BG_COLOUR;
            end
        end
    end
endmodule
